// File: rtl/ysyx_24110026_ifu_pkg.sv
// Shared definitions for the RV32E instruction fetch unit.
// Holds the fetch FSM state encoding, the default reset PC, the instruction
// width, and a helper that word-aligns a fetch address.
package ysyx_24110026_ifu_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h8000_0000;

  // S_IDLE : one-cycle post-reset state, no request issued
  // S_REQ  : request presented to instruction memory
  // S_WAIT : request accepted, waiting for the single response
  // S_HOLD : fetched instruction presented to decode
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_e;

  // Fetch addresses are always word aligned; low two bits are discarded.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_24110026_ifu.sv
// Instruction fetch unit: holds the PC, issues one imem read at a time, hands pc/inst to decode.
// Latency: best case 3 cycles/instruction (accept N, response N+1, out_valid N+2, next request N+3).
// Backpressure: holds the request until imem_req_ready; holds out_* stable until out_ready or redirect.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   imem_req_valid/ready/addr         fetch request (addr = pc_q, word aligned)
//   imem_resp_valid/data              single-cycle response pulse, one per accepted request
//   redirect_valid/redirect_pc        PC change from execute (branch/jal/jalr)
//   out_valid/ready, out_pc/out_inst  fetched instruction to decode
//
// All outputs come straight from registers; there is no input-to-output path.
module ysyx_24110026_ifu
  import ysyx_24110026_ifu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,

  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,

  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst
);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              drop_q, drop_d;     // the outstanding response is wrong-path
  logic              pend_q, pend_d;     // redirect seen while request not yet accepted
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

  logic [ADDR_W-1:0] redirect_tgt;

  assign redirect_tgt = align_pc(redirect_pc);

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      drop_q    <= 1'b0;
      pend_q    <= 1'b0;
      pend_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      drop_q    <= drop_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    drop_d    = drop_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) begin
          pc_d = redirect_tgt;
        end
      end

      S_REQ: begin
        if (imem_req_ready) begin
          // The request that just went out fetches the old pc_q. If a
          // redirect is arriving now or was deferred earlier, that fetch is
          // wrong-path: retarget the PC and drop its response.
          state_d = S_WAIT;
          pend_d  = 1'b0;
          if (redirect_valid) begin
            pc_d   = redirect_tgt;
            drop_d = 1'b1;
          end else if (pend_q) begin
            pc_d   = pend_pc_q;
            drop_d = 1'b1;
          end
        end else if (redirect_valid) begin
          // Address must stay stable until accepted, so the redirect is
          // parked; a later one simply overwrites it.
          pend_d    = 1'b1;
          pend_pc_d = redirect_tgt;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          if (imem_resp_valid) begin
            // Response for the old path lands in the same cycle: it is the
            // one being dropped, so nothing remains outstanding.
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = imem_resp_data;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // Redirect wins over consumption: the held instruction is wrong-path.
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = S_REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Outputs (registered state only)
  // ------------------------------------------------------------------
  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign out_valid      = (state_q == S_HOLD);
  assign out_pc         = pc_q;
  assign out_inst       = inst_q;

endmodule

// File: tb/tb_ysyx_24110026_ifu.sv
// Directed testbench for ysyx_24110026_ifu.
// A small behavioural instruction memory answers each accepted request after
// resp_lat cycles; scenario tasks drive inputs on negedge and check outputs there.
module tb_ysyx_24110026_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data  = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int n_checks = 0;
  int n_fail   = 0;
  int resp_lat = 1;

  ysyx_24110026_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: reset vector holds addi x1,x0,1; elsewhere an address-derived pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    return a ^ 32'h5A5A_0000;
  endfunction

  logic        mem_acc;
  logic [31:0] mem_acc_addr;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt  = 0;

  always @(posedge clk) begin
    mem_acc      = imem_req_valid && imem_req_ready;
    mem_acc_addr = imem_req_addr;
    #1;
    imem_resp_valid = 1'b0;
    if (mem_acc) begin
      mem_addr = mem_acc_addr;
      mem_cnt  = resp_lat;
    end
    if (mem_cnt != 0) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leaves the DUT in IDLE at a negedge, inputs at idle values.
  task automatic do_reset();
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    resp_lat       = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_wait_out: out_valid=%b after %0d cycles, required 1", tag, out_valid, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_out_pc: got %h want 80000000", out_pc); end
    n_checks++;
    if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_out_inst: got %h want 00000000", out_inst); end
    n_checks++;
    if (imem_req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_req_addr: got %h want 80000000", imem_req_addr); end
  endtask

  task automatic test_basic();
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b1; resp_lat = 1;
    @(negedge clk);
    n_checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0000}) begin
      n_fail++; $display("FAIL basic_req1: got %h want %h", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8000_0000});
    end
    @(negedge clk);
    n_checks++;
    if ({imem_req_valid, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL basic_wait: req_valid/out_valid got %b want 00", {imem_req_valid, out_valid});
    end
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h8000_0000, 32'h0010_0093}) begin
      n_fail++; $display("FAIL basic_out: got %h want %h", {out_valid, out_pc, out_inst}, {1'b1, 32'h8000_0000, 32'h0010_0093});
    end
    @(negedge clk);
    n_checks++;
    if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, 32'h8000_0004, 1'b0}) begin
      n_fail++; $display("FAIL basic_req2: got %h want %h", {imem_req_valid, imem_req_addr, out_valid}, {1'b1, 32'h8000_0004, 1'b0});
    end
  endtask

  task automatic test_stall();
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b0; resp_lat = 1;
    wait_out("stall");
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, out_pc, out_inst, imem_req_valid} !== {1'b1, 32'h8000_0000, 32'h0010_0093, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h want %h", i, {out_valid, out_pc, out_inst, imem_req_valid},
                           {1'b1, 32'h8000_0000, 32'h0010_0093, 1'b0});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, 32'h8000_0004, 1'b0}) begin
      n_fail++; $display("FAIL stall_release: got %h want %h", {imem_req_valid, imem_req_addr, out_valid}, {1'b1, 32'h8000_0004, 1'b0});
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b1; resp_lat = 2;
    @(negedge clk);                       // REQ, accepted at next edge
    @(negedge clk);                       // WAIT, response still one cycle away
    n_checks++;
    if ({imem_req_valid, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL rdw_in_wait: got %b want 00", {imem_req_valid, out_valid});
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if ({imem_req_valid, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL rdw_still_wait: got %b want 00", {imem_req_valid, out_valid});
    end
    @(negedge clk);                       // stale response dropped
    n_checks++;
    if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, 32'h8000_0100, 1'b0}) begin
      n_fail++; $display("FAIL rdw_req: got %h want %h", {imem_req_valid, imem_req_addr, out_valid}, {1'b1, 32'h8000_0100, 1'b0});
    end
    wait_out("rdw");
    n_checks++;
    if ({out_pc, out_inst} !== {32'h8000_0100, mem_word(32'h8000_0100)}) begin
      n_fail++; $display("FAIL rdw_out: got %h want %h", {out_pc, out_inst}, {32'h8000_0100, mem_word(32'h8000_0100)});
    end
    // Redirect in the same cycle as the response: that response is the dropped one.
    resp_lat = 1;
    @(negedge clk);
    n_checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0104}) begin
      n_fail++; $display("FAIL rdw_seq_req: got %h want %h", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8000_0104});
    end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, 32'h8000_0200, 1'b0}) begin
      n_fail++; $display("FAIL rdw_same_req: got %h want %h", {imem_req_valid, imem_req_addr, out_valid}, {1'b1, 32'h8000_0200, 1'b0});
    end
    wait_out("rdw_same");
    n_checks++;
    if ({out_pc, out_inst} !== {32'h8000_0200, mem_word(32'h8000_0200)}) begin
      n_fail++; $display("FAIL rdw_same_out: got %h want %h", {out_pc, out_inst}, {32'h8000_0200, mem_word(32'h8000_0200)});
    end
  endtask

  task automatic test_req_stall();
    do_reset();
    imem_req_ready = 1'b0; out_ready = 1'b1; resp_lat = 1;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0000}) begin
        n_fail++; $display("FAIL rqs_hold%0d: got %h want %h", i, {imem_req_valid, imem_req_addr}, {1'b1, 32'h8000_0000});
      end
      if (i == 2) imem_req_ready = 1'b1;
      else @(negedge clk);
      redirect_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({imem_req_valid, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL rqs_wait: got %b want 00", {imem_req_valid, out_valid});
    end
    @(negedge clk);
    n_checks++;
    if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, 32'h8000_0040, 1'b0}) begin
      n_fail++; $display("FAIL rqs_req: got %h want %h", {imem_req_valid, imem_req_addr, out_valid}, {1'b1, 32'h8000_0040, 1'b0});
    end
    wait_out("rqs");
    n_checks++;
    if ({out_pc, out_inst} !== {32'h8000_0040, mem_word(32'h8000_0040)}) begin
      n_fail++; $display("FAIL rqs_out: got %h want %h", {out_pc, out_inst}, {32'h8000_0040, mem_word(32'h8000_0040)});
    end
  endtask

  task automatic test_hold_redirect();
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b0; resp_lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0008;   // redirect while IDLE
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0008}) begin
      n_fail++; $display("FAIL hrd_idle_req: got %h want %h", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8000_0008});
    end
    wait_out("hrd");
    n_checks++;
    if ({out_pc, out_inst} !== {32'h8000_0008, mem_word(32'h8000_0008)}) begin
      n_fail++; $display("FAIL hrd_out: got %h want %h", {out_pc, out_inst}, {32'h8000_0008, mem_word(32'h8000_0008)});
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0020; out_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, 32'h8000_0020, 1'b0}) begin
      n_fail++; $display("FAIL hrd_req: got %h want %h", {imem_req_valid, imem_req_addr, out_valid}, {1'b1, 32'h8000_0020, 1'b0});
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b0; resp_lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;   // low bits must be cleared
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_fail++; $display("FAIL wrap_req: got %h want %h", {imem_req_valid, imem_req_addr}, {1'b1, 32'hFFFF_FFFC});
    end
    wait_out("wrap");
    n_checks++;
    if ({out_pc, out_inst} !== {32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)}) begin
      n_fail++; $display("FAIL wrap_out: got %h want %h", {out_pc, out_inst}, {32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; resp_lat = 2;
    n_checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0000_0000}) begin
      n_fail++; $display("FAIL wrap_next: got %h want %h", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0000_0000});
    end
    @(negedge clk);                       // WAIT, response in flight
    n_checks++;
    if ({imem_req_valid, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL wrap_wait: got %b want 00", {imem_req_valid, out_valid});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({imem_req_valid, out_valid, out_pc, out_inst, imem_req_addr} !== {2'b00, 32'h8000_0000, 32'h0, 32'h8000_0000}) begin
      n_fail++; $display("FAIL rst_mid: got %h want %h", {imem_req_valid, out_valid, out_pc, out_inst, imem_req_addr},
                         {2'b00, 32'h8000_0000, 32'h0, 32'h8000_0000});
    end
    @(negedge clk);                       // stale response arrives while IDLE
    n_checks++;
    if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, 32'h8000_0000, 1'b0}) begin
      n_fail++; $display("FAIL rst_first_req: got %h want %h", {imem_req_valid, imem_req_addr, out_valid}, {1'b1, 32'h8000_0000, 1'b0});
    end
    wait_out("rst");
    n_checks++;
    if ({out_pc, out_inst} !== {32'h8000_0000, 32'h0010_0093}) begin
      n_fail++; $display("FAIL rst_out: got %h want %h", {out_pc, out_inst}, {32'h8000_0000, 32'h0010_0093});
    end
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_req_stall();
    test_hold_redirect();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
